// File: rtl/harris_pkg.sv
// Shared constants and FSM state type for the Harris corner scan controller.
package harris_pkg;

    localparam int WIN_SIZE  = 6;
    localparam int GRAD_SIZE = 4;
    localparam int SCORE_W   = 64;
    localparam int COORD_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/harris_tag_delay.sv
// LAT-deep shift register carrying a window-valid flag and its top-left
// coordinates so they line up with the score returned by the datapath.
module harris_tag_delay
    import harris_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y
);

    logic [LAT-1:0]     vld;
    logic [COORD_W-1:0] xs [LAT];
    logic [COORD_W-1:0] ys [LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            xs[0]  <= in_x;
            ys[0]  <= in_y;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                xs[i]  <= xs[i-1];
                ys[i]  <= ys[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_x     = xs[LAT-1];
    assign out_y     = ys[LAT-1];

endmodule

// File: rtl/harris_scan_ctrl.sv
// Raster-scan controller for a 6x6 Harris window pipeline: pixel flow, window
// valid, score alignment and corner flagging. Macro HARRIS_CORNER_CNT_EN enables the corner counter.
module harris_scan_ctrl
    import harris_pkg::*;
#(
    parameter int                 IMG_W  = 64,
    parameter int                 IMG_H  = 64,
    parameter int                 LAT    = 3,
    parameter logic signed [63:0] THRESH = 64'sd1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic                      lb_shift,
    output logic                      win_valid,
    input  logic signed [SCORE_W-1:0] R,
    output logic                      corner,
    output logic [COORD_W-1:0]        corner_x,
    output logic [COORD_W-1:0]        corner_y,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               count
);

    state_t             state;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [15:0]        drain_cnt;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;
    logic               accept;
    logic               win_hit;
    logic               at_last;
    logic               tag_valid;
    logic [COORD_W-1:0] tag_x;
    logic [COORD_W-1:0] tag_y;
    logic               corner_hit;

    assign accept   = pix_valid & pix_ready;
    assign lb_shift = accept;
    assign win_hit  = (row >= COORD_W'(WIN_SIZE-1)) && (col >= COORD_W'(WIN_SIZE-1));
    assign at_last  = (row == COORD_W'(IMG_H-1)) && (col == COORD_W'(IMG_W-1));

    // The last pixel wins over the first-window transition so a 6x6 image goes straight to DRAIN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            drain_cnt  <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        row       <= '0;
                        col       <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FILL, RUN: begin
                    if (accept) begin
                        win_valid <= win_hit;
                        win_x     <= col - COORD_W'(WIN_SIZE-1);
                        win_y     <= row - COORD_W'(WIN_SIZE-1);
                        if (col == COORD_W'(IMG_W-1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (at_last) begin
                            state     <= DRAIN;
                            pix_ready <= 1'b0;
                            drain_cnt <= '0;
                        end else if (win_hit) begin
                            state <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 16'(LAT-1)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    harris_tag_delay #(
        .LAT(LAT)
    ) u_tag_delay (
        .clk      (clk),
        .reset    (reset),
        .in_valid (win_valid),
        .in_x     (win_x),
        .in_y     (win_y),
        .out_valid(tag_valid),
        .out_x    (tag_x),
        .out_y    (tag_y)
    );

    assign corner_hit = tag_valid && ($signed(R) >= $signed(THRESH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            corner   <= 1'b0;
            corner_x <= '0;
            corner_y <= '0;
        end else begin
            corner <= corner_hit;
            if (tag_valid) begin
                corner_x <= tag_x;
                corner_y <= tag_y;
            end
        end
    end

`ifdef HARRIS_CORNER_CNT_EN
    logic [15:0] corner_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            corner_cnt <= '0;
        end else if (state == IDLE && start) begin
            corner_cnt <= '0;
        end else if (corner_hit && corner_cnt != 16'hFFFF) begin
            corner_cnt <= corner_cnt + 1'b1;
        end
    end

    assign count = corner_cnt;
`else
    assign count = 16'd0;
`endif

endmodule

// File: tb/tb_harris_scan_ctrl.sv
// Directed bench for harris_scan_ctrl on an 8x8 image with LAT=3, THRESH=1.
module tb_harris_scan_ctrl;

    localparam int                 W   = 8;
    localparam int                 H   = 8;
    localparam int                 L   = 3;
    localparam logic signed [63:0] TH  = 64'sd1;
`ifdef HARRIS_CORNER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [63:0] r_in = '0;
    logic        pix_ready;
    logic        lb_shift;
    logic        win_valid;
    logic        corner;
    logic [15:0] corner_x;
    logic [15:0] corner_y;
    logic        busy;
    logic        frame_done;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt, win_cnt, first_win_acc, last_acc_cyc, nfd, fd_cyc, ncorn, shift_err;
    int cxs [16];
    int cys [16];

    always #5 clk = ~clk;

    harris_scan_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .LAT   (L),
        .THRESH(TH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .lb_shift  (lb_shift),
        .win_valid (win_valid),
        .R         (r_in),
        .corner    (corner),
        .corner_x  (corner_x),
        .corner_y  (corner_y),
        .busy      (busy),
        .frame_done(frame_done),
        .count     (count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (lb_shift !== (pix_valid & pix_ready)) shift_err++;
        if (win_valid === 1'b1) begin
            if (win_cnt == 0) first_win_acc = acc_cnt;
            win_cnt++;
        end
        if ((pix_valid & pix_ready) === 1'b1) begin
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (corner === 1'b1) begin
            if (ncorn < 16) begin
                cxs[ncorn] = int'(corner_x);
                cys[ncorn] = int'(corner_y);
            end
            ncorn++;
        end
        if (frame_done === 1'b1) begin
            nfd++;
            fd_cyc = cyc;
        end
    end

    task automatic clear_stats();
        acc_cnt = 0; win_cnt = 0; first_win_acc = -1; last_acc_cyc = 0;
        nfd = 0; fd_cyc = 0; ncorn = 0; shift_err = 0;
    endtask

    task automatic run_frame(input logic [63:0] r, input bit rnd, input int mid_start);
        clear_stats();
        r_in = r;
        @(posedge clk); #1;
        start = 1'b1;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3000 && nfd == 0; i++) begin
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (mid_start > 0 && acc_cnt == mid_start);
            @(posedge clk); #1;
        end
        start = 1'b0;
        pix_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input bit exp_corner);
        int exp_n;
        int exp_c;
        exp_n = exp_corner ? 9 : 0;
        exp_c = (exp_corner && CNT_EN) ? 9 : 0;
        checks++; if (acc_cnt !== W*H) begin errors++; $display("[TB] FAIL %s accepts: got %0d want %0d", name, acc_cnt, W*H); end
        checks++; if (win_cnt !== 9) begin errors++; $display("[TB] FAIL %s win_valid pulses: got %0d want 9", name, win_cnt); end
        checks++; if (first_win_acc !== 46) begin errors++; $display("[TB] FAIL %s first window after accept: got %0d want 46", name, first_win_acc); end
        checks++; if (nfd !== 1) begin errors++; $display("[TB] FAIL %s frame_done pulses: got %0d want 1", name, nfd); end
        checks++; if (fd_cyc - last_acc_cyc !== 4) begin errors++; $display("[TB] FAIL %s frame_done delay: got %0d want 4", name, fd_cyc - last_acc_cyc); end
        checks++; if (ncorn !== exp_n) begin errors++; $display("[TB] FAIL %s corners: got %0d want %0d", name, ncorn, exp_n); end
        if (exp_corner) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (cxs[k] !== k % 3 || cys[k] !== k / 3) begin
                    errors++;
                    $display("[TB] FAIL %s corner%0d xy: got (%0d,%0d) want (%0d,%0d)", name, k, cxs[k], cys[k], k % 3, k / 3);
                end
            end
        end
        checks++; if (count !== 16'(exp_c)) begin errors++; $display("[TB] FAIL %s count: got %0d want %0d", name, count, exp_c); end
        checks++; if (shift_err !== 0) begin errors++; $display("[TB] FAIL %s lb_shift vs accept: got %0d bad cycles want 0", name, shift_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy after frame: got %b want 0", name, busy); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pix_ready, lb_shift, win_valid, corner, busy, frame_done} !== 6'b0 || count !== 16'd0 ||
            corner_x !== 16'd0 || corner_y !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got rdy=%b win=%b cor=%b busy=%b fd=%b cnt=%0d xy=(%0d,%0d) want all 0",
                     pix_ready, win_valid, corner, busy, frame_done, count, corner_x, corner_y);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        run_frame(64'd1, 1'b0, 0);
        check_frame("r_one", 1'b1);
        checks++;
        if (corner_x !== 16'd2 || corner_y !== 16'd2) begin
            errors++;
            $display("[TB] FAIL held corner xy: got (%0d,%0d) want (2,2)", corner_x, corner_y);
        end
    endtask

    task automatic test_below_thresh();
        run_frame(64'd0, 1'b0, 0);
        check_frame("r_zero", 1'b0);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        check_frame("r_neg", 1'b0);
    endtask

    task automatic test_stall();
        run_frame(64'd1, 1'b1, 0);
        check_frame("stall", 1'b1);
    endtask

    task automatic test_reset_abort();
        clear_stats();
        r_in = 64'd1;
        @(posedge clk); #1;
        start = 1'b1;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt < 30; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pix_ready !== 1'b0 || count !== 16'd0 || win_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort state: got busy=%b rdy=%b cnt=%0d win=%b want 0", busy, pix_ready, count, win_valid);
        end
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (nfd !== 0) begin errors++; $display("[TB] FAIL abort frame_done: got %0d want 0", nfd); end
        checks++; if (ncorn !== 0) begin errors++; $display("[TB] FAIL abort corners: got %0d want 0", ncorn); end
        run_frame(64'd1, 1'b0, 0);
        check_frame("after_abort", 1'b1);
    endtask

    task automatic test_start_ignored();
        run_frame(64'd1, 1'b0, 20);
        check_frame("mid_start", 1'b1);
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_full_frame();
        test_below_thresh();
        test_stall();
        test_reset_abort();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
